// File: rtl/hier_fanout_node.sv
// hier_fanout_node: broadcasts one command to NUM_CHILD staggered leaf workers and serialises their results round-robin.
// Optional feature macro: HIER_NODE_ABORT_EN adds an abort input that cancels a running command.
module hier_fanout_node #(
  parameter int NUM_CHILD = 15,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 8,
  localparam int ID_W     = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ID_W-1:0]   rsp_id,
  output logic              busy
`ifdef HIER_NODE_ABORT_EN
  ,
  input  logic              abort
`endif
);
  localparam int CW = CNT_W + ID_W;
  localparam logic [ID_W:0] LAST_DLV = (ID_W+1)'(NUM_CHILD - 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CHILD - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t              state_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W:0]       dlv_q;
  logic [ID_W-1:0]     nxt_ptr, start, gnt_id, idx;
  logic [NUM_CHILD-1:0] pend_v;
  logic                accept, hs, abort_run, can_gnt, gnt_v;

  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q == RUN;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign accept    = cmd_valid && cmd_ready;
  assign hs        = rsp_valid_q && rsp_ready;
`ifdef HIER_NODE_ABORT_EN
  assign abort_run = abort && busy;
`else
  assign abort_run = 1'b0;
`endif
  assign nxt_ptr = (rsp_id_q == LAST_ID) ? '0 : rsp_id_q + 1'b1;
  assign start   = hs ? nxt_ptr : rr_ptr_q;
  assign can_gnt = busy && !abort_run && (!rsp_valid_q || hs);

  for (genvar c = 0; c < NUM_CHILD; c++) begin : child
    logic [CW-1:0] cnt_q;
    logic          pend_q, done_q, hit;
    assign hit       = gnt_v && gnt_id == ID_W'(c);
    assign pend_v[c] = pend_q;
    // Leaf worker: count down the staggered delay, then request delivery exactly once.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        pend_q <= 1'b0;
        done_q <= 1'b0;
      end else if (accept || abort_run) begin
        cnt_q  <= accept ? CW'(cmd_len) + CW'(c) : '0;
        pend_q <= 1'b0;
        done_q <= 1'b0;
      end else if (busy) begin
        cnt_q  <= (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        pend_q <= !hit && (pend_q || (cnt_q == '0 && !done_q));
        done_q <= done_q || hit;
      end
    end
  end

  // Round-robin pick of the first pending child, starting just past the last delivered id.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      idx = ID_W'((int'(start) + k) % NUM_CHILD);
      if (can_gnt && !gnt_v && pend_v[idx]) begin
        gnt_v  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  // Control FSM with registered response port; a grant reloads the output in the handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
      dlv_q       <= '0;
    end else if (state_q == IDLE) begin
      if (cmd_valid) begin
        state_q  <= RUN;
        data_q   <= cmd_data;
        rr_ptr_q <= '0;
        dlv_q    <= '0;
      end
    end else if (abort_run) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
    end else begin
      if (hs) begin
        dlv_q    <= dlv_q + 1'b1;
        rr_ptr_q <= nxt_ptr;
        state_q  <= (dlv_q == LAST_DLV) ? IDLE : RUN;
      end
      if (gnt_v) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= data_q + DATA_W'(gnt_id);
        rsp_id_q    <= gnt_id;
      end else if (hs) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end
endmodule
